// File: rtl/uart_defines.sv
// uart_defines: shared encodings and defaults for the UART transmit path.
// The GAP state encoding exists only when UART_TX_CTRL_GAP_EN is defined.
package uart_defines;

  // Default RAM address width; also the width of the burst length field.
  localparam int ADDR_W_DEF   = 8;
  // Default number of idle bit-times between frames when the gap is compiled in.
  localparam int GAP_BITS_DEF = 2;
  // System clocks per bit time used by the benches' baud generator.
  localparam int BIT_CLKS     = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_LATCH = 3'd2,
    ST_REQ   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_FIN   = 3'd5
`ifdef UART_TX_CTRL_GAP_EN
    ,
    ST_GAP   = 3'd6
`endif
  } tx_ctrl_state_e;

endpackage

// File: rtl/uart_gap_cnt.sv
// uart_gap_cnt: bit-time down-counter for the inter-frame gap.
// load presets the count; expire pulses on the tick that consumes the last bit-time.
// Only instantiated when UART_TX_CTRL_GAP_EN is defined.
module uart_gap_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins over a tick; the counter parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign expire = tick && !load && (cnt_q == CNT_W'(1));

  // Count register with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: reads a burst of bytes from a synchronous-read RAM and hands
// them one at a time to uart_tx, waiting for each stop bit before the next fetch.
// Optional feature: define UART_TX_CTRL_GAP_EN to insert GAP_BITS idle bit-times
// between frames (adds the GAP state and a uart_gap_cnt instance).
module uart_tx_ctrl
  import uart_defines::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int GAP_BITS = GAP_BITS_DEF
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              bps_clk_up,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic              abort,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [7:0]        ram_rd_data,
  output logic              tx_ready,
  output logic [7:0]        tx_data_o,
  input  logic              tx_idle,
  input  logic              tx_bits_ok,
  output logic              busy,
  output logic              done
);

  if ((GAP_BITS < 1) || (GAP_BITS > 15)) begin : g_gap_range
    $error("uart_tx_ctrl: GAP_BITS must be in 1..15");
  end

  tx_ctrl_state_e    state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic [ADDR_W-1:0] ram_rd_addr_q, ram_rd_addr_d;
  logic              ram_rd_en_q, ram_rd_en_d;
  logic              tx_ready_q, tx_ready_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  // Set once the RAM word has been captured, so a long tx_idle wait in LATCH
  // does not pick up whatever the RAM drives after its read cycle.
  logic              held_q, held_d;
  logic [ADDR_W-1:0] addr_inc;

  assign addr_inc = addr_q + 1'b1;

`ifdef UART_TX_CTRL_GAP_EN
  logic gap_load;
  logic gap_expire;

  uart_gap_cnt #(
    .CNT_W(4)
  ) u_gap_cnt (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val (4'(GAP_BITS)),
    .tick     (bps_clk_up),
    .expire   (gap_expire)
  );
`endif

  // Next-state and next-output logic for the burst sequencer.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remain_d      = remain_q;
    ram_rd_addr_d = ram_rd_addr_q;
    ram_rd_en_d   = 1'b0;
    tx_ready_d    = tx_ready_q;
    tx_data_d     = tx_data_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    held_d        = held_q;
`ifdef UART_TX_CTRL_GAP_EN
    gap_load      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            addr_d        = base_addr;
            remain_d      = len;
            ram_rd_en_d   = 1'b1;
            ram_rd_addr_d = base_addr;
            busy_d        = 1'b1;
            state_d       = ST_RD;
          end else begin
            done_d  = 1'b1;
            state_d = ST_FIN;
          end
        end
      end
      ST_RD: begin
        held_d  = 1'b0;
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        if (!held_q) begin
          tx_data_d = ram_rd_data;
        end
        held_d = 1'b1;
        if (tx_idle) begin
          tx_ready_d = 1'b1;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bps_clk_up) begin
          tx_ready_d = 1'b0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tx_bits_ok) begin
          addr_d   = addr_inc;
          remain_d = remain_q - 1'b1;
          if ((remain_q == ADDR_W'(1)) || abort) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_FIN;
          end else begin
`ifdef UART_TX_CTRL_GAP_EN
            gap_load = 1'b1;
            state_d  = ST_GAP;
`else
            ram_rd_en_d   = 1'b1;
            ram_rd_addr_d = addr_inc;
            state_d       = ST_RD;
`endif
          end
        end
      end
`ifdef UART_TX_CTRL_GAP_EN
      ST_GAP: begin
        if (abort) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_FIN;
        end else if (gap_expire) begin
          ram_rd_en_d   = 1'b1;
          ram_rd_addr_d = addr_q;
          state_d       = ST_RD;
        end
      end
`endif
      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything and drops any burst.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      remain_q      <= '0;
      ram_rd_addr_q <= '0;
      ram_rd_en_q   <= 1'b0;
      tx_ready_q    <= 1'b0;
      tx_data_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      held_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remain_q      <= remain_d;
      ram_rd_addr_q <= ram_rd_addr_d;
      ram_rd_en_q   <= ram_rd_en_d;
      tx_ready_q    <= tx_ready_d;
      tx_data_q     <= tx_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      held_q        <= held_d;
    end
  end

  assign ram_rd_en   = ram_rd_en_q;
  assign ram_rd_addr = ram_rd_addr_q;
  assign tx_ready    = tx_ready_q;
  assign tx_data_o   = tx_data_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
